// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the 5-stage datapath and pipeline_ctrl.
// The datapath side uses master; the controller uses slave.
interface pipeline_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic             imem_busy;
  logic             dmem_busy;
  logic             muldiv_busy;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_target;

  logic             stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_id, flush_ex, flush_mem, flush_wb;
  logic             pc_load;
  logic [XLEN-1:0]  pc_target;
  logic             fetch_discard;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output imem_busy, dmem_busy, muldiv_busy, id_rs1, id_rs2, id_use_rs1,
           id_use_rs2, ex_is_load, ex_rd, ex_redirect, ex_target,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           flush_mem, flush_wb, pc_load, pc_target, fetch_discard,
           stall_cycles, flush_count
  );

  modport slave (
    input  imem_busy, dmem_busy, muldiv_busy, id_rs1, id_rs2, id_use_rs1,
           id_use_rs2, ex_is_load, ex_rd, ex_redirect, ex_target,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
           flush_mem, flush_wb, pc_load, pc_target, fetch_discard,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/PC-redirect controller for the 5-stage pipeline.
// A redirect that hits a busy fetch parks in DRAIN until the stale response returns.
module pipeline_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, ex_stall, load_use, redirect_acc;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb;
  logic pc_load, fetch_discard;
  logic [XLEN-1:0] pc_target;

  assign mem_stall = bus.dmem_busy;
  assign ex_stall  = bus.muldiv_busy;
  assign load_use  = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_comb begin
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    stall_ex      = 1'b0;
    stall_mem     = 1'b0;
    flush_id      = 1'b0;
    flush_ex      = 1'b0;
    flush_mem     = 1'b0;
    flush_wb      = 1'b0;
    pc_load       = 1'b0;
    pc_target     = '0;
    fetch_discard = 1'b0;
    redirect_acc  = 1'b0;
    state_d       = state_q;
    tgt_d         = tgt_q;

    if (reset) begin
      state_d = RUN;
    end else if (state_q == DRAIN) begin
      // While busy the response is stale; when it goes idle the stale one lands now.
      stall_if      = 1'b1;
      flush_id      = 1'b1;
      fetch_discard = 1'b1;
      if (!bus.imem_busy) begin
        pc_load   = 1'b1;
        pc_target = tgt_q;
        state_d   = RUN;
      end
      // IF/ID already holds a bubble here, so holding it is as good as flushing it.
      if (mem_stall) begin
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
        flush_id  = 1'b0;
      end else if (ex_stall) begin
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
        flush_id  = 1'b0;
      end
    end else begin
      if (mem_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (ex_stall) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (bus.ex_redirect) begin
        redirect_acc = 1'b1;
        flush_id     = 1'b1;
        flush_ex     = 1'b1;
        if (bus.imem_busy) begin
          stall_if = 1'b1;
          tgt_d    = bus.ex_target;
          state_d  = DRAIN;
        end else begin
          pc_load   = 1'b1;
          pc_target = bus.ex_target;
        end
      end else if (load_use) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (bus.imem_busy) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_if};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, redirect_acc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_if      = stall_if;
  assign bus.stall_id      = stall_id;
  assign bus.stall_ex      = stall_ex;
  assign bus.stall_mem     = stall_mem;
  assign bus.flush_id      = flush_id;
  assign bus.flush_ex      = flush_ex;
  assign bus.flush_mem     = flush_mem;
  assign bus.flush_wb      = flush_wb;
  assign bus.pc_load       = pc_load;
  assign bus.pc_target     = pc_target;
  assign bus.fetch_discard = fetch_discard;
  assign bus.stall_cycles  = stall_cnt_q;
  assign bus.flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed test-plan sequences, then random traffic,
// each cycle's expected controls queued by a reference model and checked by a monitor.
module tb_pipeline_ctrl;
  localparam int XLEN  = 64;
  localparam int CNT_W = 64;

  typedef struct {
    logic            rst, ib, db, mb;
    logic [4:0]      rs1, rs2;
    logic            u1, u2, ld;
    logic [4:0]      rd;
    logic            redir;
    logic [XLEN-1:0] tgt;
  } stim_t;

  // flags: {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, pc_load, fetch_discard}
  typedef struct {
    logic [9:0]       flags;
    logic [XLEN-1:0]  pct;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();
  pipeline_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit               m_drain;
  logic [XLEN-1:0]  m_tgt;
  logic [CNT_W-1:0] m_sc, m_fc;

  function automatic exp_t model(input stim_t s, output bit accepted);
    exp_t e;
    bit sif, sid, sex, smem, fid, fex, fmem, fwb, pl, fd;
    bit hazard;
    {sif, sid, sex, smem, fid, fex, fmem, fwb, pl, fd} = '0;
    accepted = 0;
    e.pct = '0;
    e.sc  = m_sc;
    e.fc  = m_fc;
    hazard = s.ld && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (!s.rst) begin
      if (m_drain) begin
        sif = 1; fd = 1;
        pl  = !s.ib;
        if (pl) e.pct = m_tgt;
        if (s.db)      begin sid = 1; sex = 1; smem = 1; fwb = 1; end
        else if (s.mb) begin sid = 1; sex = 1; fmem = 1; end
        else           fid = 1;
      end else if (s.db) begin
        sif = 1; sid = 1; sex = 1; smem = 1; fwb = 1;
      end else if (s.mb) begin
        sif = 1; sid = 1; sex = 1; fmem = 1;
      end else if (s.redir) begin
        accepted = 1; fid = 1; fex = 1;
        if (s.ib) sif = 1;
        else begin pl = 1; e.pct = s.tgt; end
      end else if (hazard) begin
        sif = 1; sid = 1; fex = 1;
      end else if (s.ib) begin
        sif = 1; fid = 1;
      end
    end
    e.flags = {sif, sid, sex, smem, fid, fex, fmem, fwb, pl, fd};
    return e;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit acc;
    reset           = s.rst;
    bus.imem_busy   = s.ib;
    bus.dmem_busy   = s.db;
    bus.muldiv_busy = s.mb;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_use_rs1  = s.u1;
    bus.id_use_rs2  = s.u2;
    bus.ex_is_load  = s.ld;
    bus.ex_rd       = s.rd;
    bus.ex_redirect = s.redir;
    bus.ex_target   = s.tgt;
    e = model(s, acc);
    exp_q.push_back(e);
    if (s.rst) begin
      m_drain = 0; m_tgt = '0; m_sc = '0; m_fc = '0;
    end else begin
      m_sc = m_sc + CNT_W'(e.flags[9]);
      m_fc = m_fc + CNT_W'(acc);
      if (m_drain) begin
        if (!s.ib) m_drain = 0;
      end else if (acc && s.ib) begin
        m_drain = 1; m_tgt = s.tgt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.ib = 0; s.db = 0; s.mb = 0; s.rs1 = 0; s.rs2 = 0;
    s.u1 = 0; s.u2 = 0; s.ld = 0; s.rd = 0; s.redir = 0; s.tgt = '0;
    return s;
  endfunction

  // Monitor: outputs are combinational, so every cycle with a queued entry is compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e = exp_q.pop_front();
      act = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem, bus.flush_id,
             bus.flush_ex, bus.flush_mem, bus.flush_wb, bus.pc_load, bus.fetch_discard};
      checks++;
      if (act !== e.flags) begin
        errors++;
        $display("FAIL ctrl @%0t: got %b want %b", $time, act, e.flags);
      end
      checks++;
      if (bus.pc_target !== e.pct) begin
        errors++;
        $display("FAIL pc_target @%0t: got %h want %h", $time, bus.pc_target, e.pct);
      end
      checks++;
      if (bus.stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles @%0t: got %0d want %0d", $time, bus.stall_cycles, e.sc);
      end
      checks++;
      if (bus.flush_count !== e.fc) begin
        errors++;
        $display("FAIL flush_count @%0t: got %0d want %0d", $time, bus.flush_count, e.fc);
      end
    end
  end

  initial begin
    stim_t s;
    // Power-up reset cycle; counters are unknown until the first edge, so nothing is queued.
    s = idle();
    s.rst = 1;
    reset = 1;
    bus.imem_busy = 0; bus.dmem_busy = 0; bus.muldiv_busy = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_redirect = 0; bus.ex_target = '0;
    @(posedge clk);
    #1;
    m_drain = 0; m_tgt = '0; m_sc = '0; m_fc = '0;

    // 1: reset with every input high, then an idle cycle
    s.rst = 1; s.ib = 1; s.db = 1; s.mb = 1; s.rs1 = 5'h1f; s.rs2 = 5'h1f;
    s.u1 = 1; s.u2 = 1; s.ld = 1; s.rd = 5'h1f; s.redir = 1; s.tgt = '1;
    apply(s);
    apply(idle());

    // 2: load-use on rs2, then the same with rd=0
    s = idle(); s.ld = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
    apply(s);
    apply(idle());
    s.rd = 0; s.rs2 = 0;
    apply(s);

    // 3: redirect with fetch idle
    s = idle(); s.redir = 1; s.tgt = 64'h8000_0040;
    apply(s);
    apply(idle());

    // 4: redirect with fetch busy, drain three more busy cycles
    s = idle(); s.redir = 1; s.tgt = 64'h8000_0100; s.ib = 1;
    apply(s);
    s = idle(); s.ib = 1;
    repeat (3) apply(s);
    apply(idle());
    apply(idle());

    // 5: redirect held behind mem and ex stalls
    s = idle(); s.db = 1; s.mb = 1; s.redir = 1; s.tgt = 64'h8000_0200;
    repeat (2) apply(s);
    s.db = 0;
    apply(s);
    s.mb = 0;
    apply(s);
    apply(idle());

    // 6: reset while draining
    s = idle(); s.redir = 1; s.tgt = 64'h8000_0300; s.ib = 1;
    apply(s);
    s = idle(); s.ib = 1;
    apply(s);
    s.rst = 1;
    apply(s);
    s.rst = 0;
    apply(s);
    apply(idle());

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(0, 149) == 0);
      s.ib    = ($urandom_range(0, 2) == 0);
      s.db    = ($urandom_range(0, 5) == 0);
      s.mb    = ($urandom_range(0, 5) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.ld    = ($urandom_range(0, 2) == 0);
      s.rd    = 5'($urandom_range(0, 3));
      s.redir = ($urandom_range(0, 3) == 0);
      s.tgt   = {$urandom, $urandom};
      apply(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
